// File: rtl/rotor_stepper_if.sv
`default_nettype none
// ============================================================================
//  Module      : rotor_stepper_if
//  Description : Keyboard handshake, start-position load and rotor-chain
//                drive signals for the rotor_stepper sequencing controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface rotor_stepper_if;
   // keyboard side
   logic        key_valid;
   logic        key_ready;
   logic [25:0] in_letter;
   // start-position load
   logic        set;
   logic [4:0]  set_l;
   logic [4:0]  set_m;
   logic [4:0]  set_r;
   // rotor chain side
   logic [4:0]  pos_l;
   logic [4:0]  pos_m;
   logic [4:0]  pos_r;
   logic [25:0] letter;
   logic        out_valid;
   // status
   logic        busy;
   logic [15:0] key_count;

   // Driver of keys and start positions (keyboard / test environment)
   modport master (
      output key_valid, in_letter, set, set_l, set_m, set_r,
      input  key_ready, pos_l, pos_m, pos_r, letter, out_valid, busy, key_count
   );

   // The stepping controller itself
   modport slave (
      input  key_valid, in_letter, set, set_l, set_m, set_r,
      output key_ready, pos_l, pos_m, pos_r, letter, out_valid, busy, key_count
   );
endinterface
`default_nettype wire

// File: rtl/rotor_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : rotor_stepper
//  Description : Three-rotor Enigma stepping controller. Accepts one letter
//                per handshake, advances right/middle/left rotors with
//                ring-notch stepping (including the middle-rotor double
//                step), then holds letter and positions stable while the
//                combinational rotor/reflector chain settles and pulses
//                out_valid for one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module rotor_stepper #(
   parameter int unsigned NOTCH_R = 16,  // right-rotor turnover (Q)
   parameter int unsigned NOTCH_M = 4,   // middle-rotor turnover (E)
   parameter int unsigned NOTCH_L = 21   // left-rotor turnover (V), no fourth rotor to step
) (
   input  wire logic       clock,
   input  wire logic       resetn,
   rotor_stepper_if.slave  bus
);

   localparam logic [4:0] c_notch_r = 5'(NOTCH_R);
   localparam logic [4:0] c_notch_m = 5'(NOTCH_M);
   localparam logic [4:0] c_last    = 5'd25;

   // Notch positions outside 0..25 could never be reached by a rotor
   if (NOTCH_R > 25 || NOTCH_M > 25 || NOTCH_L > 25) begin : g_notch_check
      $error("rotor_stepper: notch parameters must lie in 0..25");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STEP   = 2'd1,
      S_SETTLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  pos_l_q, pos_l_d;
   logic [4:0]  pos_m_q, pos_m_d;
   logic [4:0]  pos_r_q, pos_r_d;
   logic [25:0] letter_q, letter_d;
   logic [15:0] count_q, count_d;

   logic        w_idle;
   logic        w_accept;
   logic        w_load;
   logic        w_step_m;
   logic        w_step_l;

   // Reduce a 5-bit start value into 0..25; 26..31 fold onto 0..5
   function automatic logic [4:0] mod26(input logic [4:0] v);
      return (v >= 5'd26) ? (v - 5'd26) : v;
   endfunction

   // Advance a rotor by one position with 25 -> 0 wrap
   function automatic logic [4:0] inc26(input logic [4:0] v);
      return (v == c_last) ? 5'd0 : (v + 5'd1);
   endfunction

   // set wins over a simultaneous key; neither is honoured outside IDLE
   assign w_idle   = (state_q == S_IDLE);
   assign w_load   = w_idle && bus.set;
   assign w_accept = w_idle && !bus.set && bus.key_valid;

   // Middle rotor moves when the right rotor sits on its notch, or when it
   // sits on its own notch (the double step); the left rotor follows the
   // middle rotor's notch. All decisions use pre-step positions.
   assign w_step_m = (pos_r_q == c_notch_r) || (pos_m_q == c_notch_m);
   assign w_step_l = (pos_m_q == c_notch_m);

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Fixed three-cycle sequence once a key is accepted
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (w_accept) state_d = S_STEP;
         S_STEP:   state_d = S_SETTLE;
         S_SETTLE: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values: load in IDLE, step in STEP, hold elsewhere
   always_comb begin
      pos_l_d  = pos_l_q;
      pos_m_d  = pos_m_q;
      pos_r_d  = pos_r_q;
      letter_d = letter_q;
      count_d  = count_q;
      if (w_load) begin
         pos_l_d = mod26(bus.set_l);
         pos_m_d = mod26(bus.set_m);
         pos_r_d = mod26(bus.set_r);
         count_d = 16'd0;
      end else if (w_accept) begin
         // latched unchecked: a non-one-hot value reaches the chain as-is
         letter_d = bus.in_letter;
      end else if (state_q == S_STEP) begin
         pos_r_d = inc26(pos_r_q);
         if (w_step_m) pos_m_d = inc26(pos_m_q);
         if (w_step_l) pos_l_d = inc26(pos_l_q);
         count_d = count_q + 16'd1;
      end
   end

   // Datapath registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pos_l_q  <= 5'd0;
         pos_m_q  <= 5'd0;
         pos_r_q  <= 5'd0;
         letter_q <= 26'd0;
         count_q  <= 16'd0;
      end else begin
         pos_l_q  <= pos_l_d;
         pos_m_q  <= pos_m_d;
         pos_r_q  <= pos_r_d;
         letter_q <= letter_d;
         count_q  <= count_d;
      end
   end

   assign bus.key_ready = w_idle && !bus.set;
   assign bus.busy      = !w_idle;
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.pos_l     = pos_l_q;
   assign bus.pos_m     = pos_m_q;
   assign bus.pos_r     = pos_r_q;
   assign bus.letter    = letter_q;
   assign bus.key_count = count_q;

endmodule
`default_nettype wire
